// File: rtl/requant_scale_pkg.sv
// requant_scale_pkg: shared widths, default scale/shift/zero-point and FSM state encodings
package requant_scale_pkg;
  localparam int ACC_W = 32;
  localparam int Q_W = 31;
  localparam int OUT_W = 9;
  localparam int CNT_W = $clog2(Q_W);
  localparam logic [Q_W-1:0] Q_MULT_DEF = 31'd2014687024;
  localparam int RSHIFT_DEF = 37;
  localparam int ZP_DEF = 0;
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, RND = 2'd2, SAT = 2'd3} state_e;
endpackage

// File: rtl/requant_scale_seq_mult.sv
// requant_scale_seq_mult: serial shift-add multiplier, acc (signed) x Q_MULT (unsigned), one bit per step, LSB first
// Ports: clk, rst, load (capture a, clear product), step (one iteration), a (signed multiplicand),
//        done_bit (current step is the last), product (64-b signed)
module requant_scale_seq_mult
  import requant_scale_pkg::*;
#(
  parameter logic [Q_W-1:0] Q_MULT = Q_MULT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [ACC_W-1:0]   a,
  output logic               done_bit,
  output logic signed [63:0] product
);
  logic signed [63:0] mcand_q, mcand_d, prod_q, prod_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // the multiplicand is shifted left each step so product += multiplicand << i needs no barrel shifter
  always_comb begin
    mcand_d = load ? {{(64-ACC_W){a[ACC_W-1]}}, a} : step ? mcand_q <<< 1 : mcand_q;
    prod_d = load ? '0 : (step && Q_MULT[cnt_q]) ? prod_q + mcand_q : prod_q;
    cnt_d = load ? '0 : step ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      prod_q <= '0;
      cnt_q <= '0;
    end else begin
      mcand_q <= mcand_d;
      prod_q <= prod_d;
      cnt_q <= cnt_d;
    end
  end
  assign done_bit = cnt_q == CNT_W'(Q_W - 1);
  assign product = prod_q;
endmodule

// File: rtl/requant_scale.sv
// requant_scale: 32-b signed accumulator -> 9-b signed code: x Q_MULT, round half up, >>> RSHIFT, + ZP, saturate
// Ports: clk, rst (sync, active high), start, acc (signed), busy, num_quant (signed), quant_ok (1-cycle valid pulse)
module requant_scale
  import requant_scale_pkg::*;
#(
  parameter logic [Q_W-1:0] Q_MULT = Q_MULT_DEF,
  parameter int             RSHIFT = RSHIFT_DEF,
  parameter int             ZP     = ZP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ACC_W-1:0] acc,
  output logic             busy,
  output logic [OUT_W-1:0] num_quant,
  output logic             quant_ok
);
  localparam logic signed [63:0] HALF = 64'sd1 <<< (RSHIFT - 1);
  localparam logic signed [63:0] MAXV = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
  localparam logic signed [63:0] MINV = -(64'sd1 <<< (OUT_W - 1));
  state_e state_q, state_d;
  logic busy_q, busy_d, ok_q, ok_d, load, step, done_bit;
  logic [OUT_W-1:0] num_q, num_d, sat;
  logic signed [63:0] s_q, s_d, product;
  requant_scale_seq_mult #(.Q_MULT(Q_MULT)) u_mult (
    .clk(clk), .rst(rst), .load(load), .step(step), .a(acc), .done_bit(done_bit), .product(product)
  );
  always_comb begin
    state_d = state_q;
    busy_d = busy_q;
    num_d = num_q;
    s_d = s_q;
    ok_d = state_q == SAT;
    load = state_q == IDLE && start;
    step = state_q == MUL;
    sat = s_q > MAXV ? MAXV[OUT_W-1:0] : s_q < MINV ? MINV[OUT_W-1:0] : s_q[OUT_W-1:0];
    case (state_q)
      IDLE: if (start) begin
        state_d = MUL;
        busy_d = 1'b1;
      end
      MUL: if (done_bit) state_d = RND;
      RND: begin
        s_d = ((product + HALF) >>> RSHIFT) + 64'(ZP);
        state_d = SAT;
      end
      SAT: begin
        num_d = sat;
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      ok_q <= 1'b0;
      num_q <= '0;
      s_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      ok_q <= ok_d;
      num_q <= num_d;
      s_q <= s_d;
    end
  end
  assign busy = busy_q;
  assign num_quant = num_q;
  assign quant_ok = ok_q;
endmodule

// File: tb/tb_requant_scale.sv
// tb_requant_scale: directed table, latency, throughput, reset-abort and random checks for requant_scale (ZP=0 and ZP=6)
module tb_requant_scale;
  import requant_scale_pkg::*;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] acc = '0;
  logic busy0, busy6, ok0, ok6;
  logic [8:0] nq0, nq6;
  int checks = 0, errors = 0;

  typedef struct {
    logic [31:0] acc;
    int exp0;
    int exp6;
  } vec_t;
  vec_t vecs[13];

  requant_scale u_dut0 (.clk(clk), .rst(rst), .start(start), .acc(acc), .busy(busy0), .num_quant(nq0), .quant_ok(ok0));
  requant_scale #(.ZP(6)) u_dut6 (.clk(clk), .rst(rst), .start(start), .acc(acc), .busy(busy6), .num_quant(nq6), .quant_ok(ok6));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model(input logic [31:0] a, input int zp);
    longint p, r;
    p = longint'($signed(a)) * longint'(2014687024);
    r = ((p + (64'sd1 <<< 36)) >>> 37) + longint'(zp);
    return r > 255 ? 255 : r < -256 ? -256 : int'(r);
  endfunction

  // one start pulse; returns edges from accept to quant_ok and both results
  task automatic do_op(input logic [31:0] a, output int lat, output int r0, output int r6);
    int n;
    @(negedge clk);
    start = 1'b1;
    acc = a;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!ok0 && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 5) acc = ~a;
    end
    lat = n - 1;
    r0 = int'($signed(nq0));
    r6 = int'($signed(nq6));
    if (n >= 100) begin
      chk("timeout", n, 34);
    end else begin
      chk("ok6_with_ok0", int'(ok6), 1);
      chk("busy_in_ok", int'(busy0), 0);
      @(negedge clk);
      chk("ok_one_cycle", int'(ok0), 0);
    end
  endtask

  initial begin
    int lat, r0, r6, n, gap;
    vecs[0] = '{32'd1000, 15, 21};
    vecs[1] = '{-32'sd1000, -15, -9};
    vecs[2] = '{32'd0, 0, 6};
    vecs[3] = '{32'h7FFFFFFF, 255, 255};
    vecs[4] = '{32'h80000000, -256, -256};
    vecs[5] = '{32'd34, 0, 6};
    vecs[6] = '{32'd35, 1, 7};
    vecs[7] = '{-32'sd34, 0, 6};
    vecs[8] = '{-32'sd35, -1, 5};
    vecs[9] = '{32'd17000, 249, 255};
    vecs[10] = '{32'd17100, 251, 255};
    vecs[11] = '{-32'sd17500, -256, -251};
    vecs[12] = '{32'd1000, 15, 21};

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_ok", int'(ok0), 0);
    chk("rst_nq", int'(nq0), 0);
    chk("rst_nq6", int'(nq6), 0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].acc, lat, r0, r6);
      chk($sformatf("vec%0d_lat", i), lat, 33);
      chk($sformatf("vec%0d_zp0", i), r0, vecs[i].exp0);
      chk($sformatf("vec%0d_zp6", i), r6, vecs[i].exp6);
    end

    // start held high: one result every 34 cycles, busy low only in the quant_ok cycle
    @(negedge clk);
    start = 1'b1;
    acc = 32'd1000;
    n = 0;
    while (!ok0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold_first", int'(ok0), 1);
    for (int p = 0; p < 3; p++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
        if (gap == 10) acc = 32'd5;
        if (gap == 20) acc = 32'd1000;
        if (!ok0 && !busy0) chk("hold_busy_low", int'(busy0), 1);
      end while (!ok0 && gap < 100);
      chk("hold_gap", gap, 34);
      chk("hold_busy_ok", int'(busy0), 0);
      chk("hold_nq", int'($signed(nq0)), 15);
    end
    start = 1'b0;
    repeat (40) @(negedge clk);

    // reset during MUL iteration 10 discards the operation
    do_op(32'd1000, lat, r0, r6);
    @(negedge clk);
    start = 1'b1;
    acc = 32'd1000;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", int'(busy0), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(busy0), 0);
    chk("abort_nq", int'(nq0), 0);
    chk("abort_ok", int'(ok0), 0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ok0 || busy0) n++;
    end
    chk("abort_no_ok", n, 0);
    do_op(-32'sd1000, lat, r0, r6);
    chk("after_abort_lat", lat, 33);
    chk("after_abort_nq", r0, -15);
    chk("after_abort_nq6", r6, -9);

    for (int k = 0; k < 600; k++) begin
      logic [31:0] a;
      a = (k % 3 == 0) ? $urandom : 32'($signed($urandom_range(40000)) - 20000);
      do_op(a, lat, r0, r6);
      chk($sformatf("rnd%0d_zp0 acc=%0d", k, $signed(a)), r0, model(a, 0));
      chk($sformatf("rnd%0d_zp6 acc=%0d", k, $signed(a)), r6, model(a, 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
